puf_challenge_scheduler: RTL
============================

// Module: puf_challenge_scheduler
// PURPOSE
//  Sequencer for the ring-oscillator PUF array. Accepts a challenge over a valid/ready handshake,
//  runs one counter clear/count/compare measurement per response bit, compares two RO counters
//  per bit, and returns a RESP_BITS-wide PUF response. Sits between the cipher control logic and
//  the RO counter bank, and owns the counter clear/enable/select lines.
// PARAMETERS
//  NUM_RO     16  number of ring oscillators; power of two, >=2
//  CNT_W      8   RO counter width
//  WINDOW     64  count-window length in clock cycles; >=1
//  RESP_BITS  8   response bits per challenge; >=1
// PORTS
//  clock        in   1                 single clock; all logic on posedge
//  reset_n      in   1                 asynchronous, active-low reset
//  req_valid    in   1                 challenge request valid
//  req_ready    out  1                 = (state==IDLE) && reset_n
//  req_chal     in   $clog2(NUM_RO)    challenge; base RO index
//  abort        in   1                 synchronous cancel of an in-flight measurement
//  ro_clear     out  1                 clear all RO counters (one-cycle pulse)
//  ro_enable    out  1                 RO counters may increment
//  ro_sel_a     out  $clog2(NUM_RO)    first RO of the compared pair
//  ro_sel_b     out  $clog2(NUM_RO)    second RO of the compared pair
//  ro_count_a   in   CNT_W             count of ro_sel_a
//  ro_count_b   in   CNT_W             count of ro_sel_b
//  rsp_valid    out  1                 response valid; held until accepted
//  rsp_ready    in   1                 response consumer ready
//  rsp_data     out  RESP_BITS         response; bit i = result of measurement i
//  rsp_tie      out  1                 at least one compare had equal counts
//  busy         out  1                 state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; all counters and registers 0; every output 0,
//    req_ready included. Reset mid-operation aborts with no response and drops ro_enable at once.
//  - FSM states: IDLE, CLEAR, COUNT, COMPARE, DONE.
//  - IDLE: on req_valid&&req_ready, capture req_chal, set bit_idx=0, clear rsp_data/rsp_tie -> CLEAR.
//  - CLEAR: ro_clear=1 for one cycle -> COUNT.
//  - COUNT: ro_enable=1 for exactly WINDOW cycles (window counter 0..WINDOW-1) -> COMPARE.
//  - COMPARE: one cycle, ro_enable=0. Bit = (ro_count_a > ro_count_b), unsigned. Equal counts
//    give bit 0 and set rsp_tie. If bit_idx==RESP_BITS-1 -> DONE, else bit_idx++ -> CLEAR.
//  - Pair selection: ro_sel_a = (chal + 2*bit_idx) mod NUM_RO; ro_sel_b = (ro_sel_a + 1) mod
//    NUM_RO; both truncate to index width and wrap. Both stay stable from CLEAR through COMPARE.
//  - DONE: rsp_valid=1; rsp_data/rsp_tie stable until rsp_valid&&rsp_ready; then -> IDLE with
//    rsp_valid=0. rsp_data and rsp_tie keep their values until the next accept.
//  - Latency: WINDOW+2 cycles per bit. rsp_valid rises RESP_BITS*(WINDOW+2) clock edges after
//    the accepting edge.
//  - abort=1 in CLEAR/COUNT/COMPARE: -> IDLE on the next edge; no rsp_valid; rsp_data undefined
//    but held. abort has priority over the COMPARE transition. abort is ignored in IDLE and DONE.
//  - A req_valid seen while busy is not accepted (req_ready=0) and need not be held by the core.
//  - ro_clear and ro_enable are never high in the same cycle.
// CONFIGURATION
//  PUF_MAJORITY_VOTE_EN defined: each bit runs CLEAR/COUNT/COMPARE 3 times on the same pair.
//    Bit = majority of the 3 compare results; a tie counts as a 0 vote and sets rsp_tie.
//    A 2-bit vote counter is added; latency becomes 3*RESP_BITS*(WINDOW+2).
//  Not defined: a single measurement per bit as above; no vote logic is synthesised.
// TESTING (bench params NUM_RO=16, CNT_W=8, WINDOW=4, RESP_BITS=8)
//  1. reset_n=0 mid-COUNT -> all outputs 0 at once; after release req_ready=1, busy=0.
//  2. chal=4'h3; model returns count = 4*sel -> rsp_data=8'h40 (only bit6 pair 15 vs 0 is set),
//     rsp_tie=0; rsp_valid 48 edges after accept.
//  3. chal=4'h0; model returns equal counts -> rsp_data=8'h00, rsp_tie=1.
//  4. rsp_ready=0 for 10 cycles in DONE -> rsp_valid/rsp_data stable; req_ready=0; a request
//     offered then is not accepted; accepted after handshake.
//  5. abort pulsed in COUNT of bit 2 -> IDLE next edge, ro_enable=0, no rsp_valid; next request
//     completes with the correct result.
//  6. With PUF_MAJORITY_VOTE_EN: model flips only the 2nd measurement of every bit -> same
//     rsp_data as test 2 (8'h40); rsp_valid 144 edges after accept.

Source files
------------

// File: rtl/puf_challenge_scheduler_if.sv
// -----------------------------------------------------------------------------
// puf_challenge_scheduler_if
//   Challenge request / response channels between the cipher control logic
//   (master) and the PUF challenge scheduler (slave).
//
//   Signals
//     req_valid  master->slave  challenge request valid
//     req_ready  slave->master  scheduler can accept a challenge
//     req_chal   master->slave  challenge (base RO index)
//     rsp_valid  slave->master  response valid, held until accepted
//     rsp_ready  master->slave  response consumer ready
//     rsp_data   slave->master  response bits
//     rsp_tie    slave->master  at least one compare saw equal counts
// -----------------------------------------------------------------------------
interface puf_challenge_scheduler_if #(
   parameter int unsigned NUM_RO    = 16,
   parameter int unsigned RESP_BITS = 8
);

   logic                      req_valid;
   logic                      req_ready;
   logic [$clog2(NUM_RO)-1:0] req_chal;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [RESP_BITS-1:0]      rsp_data;
   logic                      rsp_tie;

   modport master (
      output req_valid,
      output req_chal,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      input  rsp_tie
   );

   modport slave (
      input  req_valid,
      input  req_chal,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      output rsp_tie
   );

endinterface

// File: rtl/puf_challenge_scheduler.sv
// -----------------------------------------------------------------------------
// puf_challenge_scheduler
//   Sequencer for the ring-oscillator PUF array. A challenge accepted on the
//   request channel selects a base RO index; for each response bit the block
//   clears the RO counters, lets them count for WINDOW cycles, then compares
//   the counts of an adjacent RO pair. The collected bits are returned on the
//   response channel and held until accepted.
//
//   Ports
//     clock       single clock, all logic on posedge
//     reset_n     asynchronous active-low reset
//     bus         request/response channels (slave side)
//     abort       synchronous cancel of an in-flight measurement
//     ro_clear    one-cycle clear pulse to the RO counter bank
//     ro_enable   RO counters may increment
//     ro_sel_a/b  compared RO pair
//     ro_count_a/b  counts of the selected pair
//     busy        scheduler not idle
//
//   Optional feature macro: PUF_MAJORITY_VOTE_EN
//     When defined, each bit is measured three times on the same pair and the
//     bit is the majority of the three compares. Otherwise one measurement per
//     bit and no vote logic.
// -----------------------------------------------------------------------------
module puf_challenge_scheduler #(
   parameter int unsigned NUM_RO    = 16,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned WINDOW    = 64,
   parameter int unsigned RESP_BITS = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   puf_challenge_scheduler_if.slave  bus,
   input  logic                      abort,
   output logic                      ro_clear,
   output logic                      ro_enable,
   output logic [$clog2(NUM_RO)-1:0] ro_sel_a,
   output logic [$clog2(NUM_RO)-1:0] ro_sel_b,
   input  logic [CNT_W-1:0]          ro_count_a,
   input  logic [CNT_W-1:0]          ro_count_b,
   output logic                      busy
);

   localparam int unsigned IDX_W = $clog2(NUM_RO);
   localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StCount,
      StCompare,
      StDone
   } state_e;

   state_e               state_q;
   logic [IDX_W-1:0]     ro_sel_a_q;
   logic [IDX_W-1:0]     ro_sel_b_q;
   logic [WIN_W-1:0]     win_q;
   logic [BIT_W-1:0]     bit_idx_q;
   logic [RESP_BITS-1:0] rsp_data_q;
   logic                 rsp_tie_q;
   logic                 rsp_valid_q;
   logic                 ro_clear_q;
   logic                 ro_enable_q;
   logic                 busy_q;

   // Result of the current compare
   logic meas_bit;
   logic meas_tie;
   // Whether this compare completes the bit, and the bit value it yields
   logic bit_done;
   logic bit_val;
   logic last_bit;

   assign meas_bit = (ro_count_a > ro_count_b);
   assign meas_tie = (ro_count_a == ro_count_b);
   assign last_bit = (bit_idx_q == BIT_W'(RESP_BITS - 1));

`ifdef PUF_MAJORITY_VOTE_EN
   logic [1:0] vote_cnt_q;
   logic [1:0] vote_ones_q;
   logic [2:0] vote_total;

   assign vote_total = {1'b0, vote_ones_q} + {2'b00, meas_bit};
   assign bit_done   = (vote_cnt_q == 2'd2);
   assign bit_val    = (vote_total >= 3'd2);
`else
   assign bit_done = 1'b1;
   assign bit_val  = meas_bit;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         ro_sel_a_q  <= '0;
         ro_sel_b_q  <= '0;
         win_q       <= '0;
         bit_idx_q   <= '0;
         rsp_data_q  <= '0;
         rsp_tie_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         ro_clear_q  <= 1'b0;
         ro_enable_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
         vote_cnt_q  <= '0;
         vote_ones_q <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               // req_ready is high whenever we are idle and out of reset
               if (bus.req_valid) begin
                  state_q    <= StClear;
                  ro_sel_a_q <= bus.req_chal;
                  ro_sel_b_q <= bus.req_chal + IDX_W'(1);
                  bit_idx_q  <= '0;
                  rsp_data_q <= '0;
                  rsp_tie_q  <= 1'b0;
                  ro_clear_q <= 1'b1;
                  busy_q     <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                  vote_cnt_q  <= '0;
                  vote_ones_q <= '0;
`endif
               end
            end

            StClear: begin
               ro_clear_q <= 1'b0;
               if (abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  state_q     <= StCount;
                  win_q       <= '0;
                  ro_enable_q <= 1'b1;
               end
            end

            StCount: begin
               if (abort) begin
                  state_q     <= StIdle;
                  ro_enable_q <= 1'b0;
                  busy_q      <= 1'b0;
               end else if (win_q == WIN_W'(WINDOW - 1)) begin
                  state_q     <= StCompare;
                  ro_enable_q <= 1'b0;
               end else begin
                  win_q <= win_q + WIN_W'(1);
               end
            end

            StCompare: begin
               if (abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  rsp_tie_q <= rsp_tie_q | meas_tie;
                  if (bit_done) begin
                     rsp_data_q[bit_idx_q] <= bit_val;
`ifdef PUF_MAJORITY_VOTE_EN
                     vote_cnt_q  <= '0;
                     vote_ones_q <= '0;
`endif
                     if (last_bit) begin
                        state_q     <= StDone;
                        rsp_valid_q <= 1'b1;
                     end else begin
                        state_q    <= StClear;
                        ro_clear_q <= 1'b1;
                        bit_idx_q  <= bit_idx_q + BIT_W'(1);
                        // Pairs advance by two; the index width makes this wrap
                        ro_sel_a_q <= ro_sel_a_q + IDX_W'(2);
                        ro_sel_b_q <= ro_sel_b_q + IDX_W'(2);
                     end
                  end else begin
`ifdef PUF_MAJORITY_VOTE_EN
                     vote_cnt_q  <= vote_cnt_q + 2'd1;
                     vote_ones_q <= vote_ones_q + {1'b0, meas_bit};
`endif
                     // Repeat the measurement on the same pair
                     state_q    <= StClear;
                     ro_clear_q <= 1'b1;
                  end
               end
            end

            StDone: begin
               if (bus.rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end

            default: begin
               state_q     <= StIdle;
               rsp_valid_q <= 1'b0;
               ro_clear_q  <= 1'b0;
               ro_enable_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // reset_n term forces req_ready low while reset is asserted
   assign bus.req_ready = (state_q == StIdle) && reset_n;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_tie   = rsp_tie_q;
   assign ro_clear      = ro_clear_q;
   assign ro_enable     = ro_enable_q;
   assign ro_sel_a      = ro_sel_a_q;
   assign ro_sel_b      = ro_sel_b_q;
   assign busy          = busy_q;

endmodule
